// File: rtl/ac_stim_nco_pkg.sv
// Shared widths, FSM and quadrant types for the sine stimulus NCO.
// Imported by the interface, the quarter-wave ROM and the top level.
package ac_stim_pkg;

  localparam int DEF_PHASE_W    = 24;
  localparam int DEF_LUT_ADDR_W = 8;
  localparam int DEF_SAMPLE_W   = 16;
  localparam int DEF_AMP_W      = 16;

  localparam int FULL_SCALE = 2 ** (DEF_SAMPLE_W - 1) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_t;

  typedef struct packed {
    logic mirror;
    logic negate;
  } quad_dec_t;

  // Second and fourth quadrants read the table backwards; the lower half-cycle is negative.
  function automatic quad_dec_t decode_quad(input quad_t q);
    quad_dec_t d;
    d.mirror = (q == Q1) || (q == Q3);
    d.negate = (q == Q2) || (q == Q3);
    return d;
  endfunction

endpackage

// File: rtl/ac_stim_nco_if.sv
// Configuration and sample-stream handshakes of the NCO.
// The slave modport is the NCO side, the master modport is the stimulus/consumer side.
interface ac_stim_nco_if
  import ac_stim_pkg::*;
#(
  parameter int PHASE_W  = DEF_PHASE_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int AMP_W    = DEF_AMP_W
);

  logic                       cfg_valid;
  logic                       cfg_ready;
  logic [PHASE_W-1:0]         cfg_freq;
  logic [PHASE_W-1:0]         cfg_phase;
  logic [AMP_W-1:0]           cfg_amp;

  logic                       out_valid;
  logic                       out_ready;
  logic signed [SAMPLE_W-1:0] out_sample;
  logic [PHASE_W-1:0]         out_phase;

  modport master (
    output cfg_valid, cfg_freq, cfg_phase, cfg_amp, out_ready,
    input  cfg_ready, out_valid, out_sample, out_phase
  );

  modport slave (
    input  cfg_valid, cfg_freq, cfg_phase, cfg_amp, out_ready,
    output cfg_ready, out_valid, out_sample, out_phase
  );

endinterface

// File: rtl/ac_stim_nco_sine_qlut.sv
// Quarter-wave sine ROM: entry i = round(full_scale * sin(i*pi/2/2^LUT_ADDR_W)), i = 0..2^LUT_ADDR_W.
// Addresses above the quarter point are never produced by the decoder and read as zero.
module sine_qlut #(
  parameter int LUT_ADDR_W = 8,
  parameter int SAMPLE_W   = 16
) (
  input  logic [LUT_ADDR_W:0]        i_addr,
  output logic signed [SAMPLE_W-1:0] o_value
);

  localparam int QUARTER   = 2 ** LUT_ADDR_W;
  localparam int ROM_DEPTH = 2 ** (LUT_ADDR_W + 1);

  function automatic int rom_entry(input int idx);
    real full_scale;
    real angle;
    if (idx > QUARTER) return 0;
    full_scale = real'(2 ** (SAMPLE_W - 1) - 1);
    angle      = real'(idx) * 3.14159265358979323846 / 2.0 / real'(QUARTER);
    return $rtoi(full_scale * $sin(angle) + 0.5);
  endfunction

  logic signed [SAMPLE_W-1:0] w_rom [ROM_DEPTH];

  // NOTE: the table is built from elaboration-time constants, so it needs no reset and no write port.
  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
    localparam logic signed [SAMPLE_W-1:0] ENTRY = SAMPLE_W'(rom_entry(g));
    assign w_rom[g] = ENTRY;
  end

  assign o_value = w_rom[i_addr];

endmodule

// File: rtl/ac_stim_nco.sv
// Sine stimulus NCO: phase accumulator, quarter-wave lookup and amplitude multiply
// in a 3-stage pipeline that stalls as a whole under output backpressure.
module ac_stim_nco
  import ac_stim_pkg::*;
#(
  parameter int PHASE_W    = DEF_PHASE_W,
  parameter int LUT_ADDR_W = DEF_LUT_ADDR_W,
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int AMP_W      = DEF_AMP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  output logic         busy,
  ac_stim_nco_if.slave bus
);

  localparam int PROD_W = SAMPLE_W + AMP_W + 1;
  localparam logic [LUT_ADDR_W:0] LUT_LEN = (LUT_ADDR_W + 1)'(2 ** LUT_ADDR_W);

  state_t                     r_state;
  logic                       r_cfg_ready;
  logic                       r_busy;
  logic [PHASE_W-1:0]         r_freq;
  logic [AMP_W-1:0]           r_amp;
  logic [PHASE_W-1:0]         r_acc;

  logic                       r_s1_valid;
  logic [PHASE_W-1:0]         r_s1_phase;
  logic                       r_s2_valid;
  logic [PHASE_W-1:0]         r_s2_phase;
  logic signed [SAMPLE_W-1:0] r_s2_lut;
  logic                       r_out_valid;
  logic [PHASE_W-1:0]         r_out_phase;
  logic signed [SAMPLE_W-1:0] r_out_sample;

  logic                       w_stall;
  logic                       w_adv;
  logic                       w_cfg_fire;
  logic                       w_issue;
  logic                       w_pipe_empty;
  quad_t                      w_quad;
  quad_dec_t                  w_dec;
  logic [LUT_ADDR_W-1:0]      w_raw_addr;
  logic [LUT_ADDR_W:0]        w_lut_addr;
  logic signed [SAMPLE_W-1:0] w_lut;
  logic signed [PROD_W-1:0]   w_lut_ext;
  logic signed [PROD_W-1:0]   w_amp_ext;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [SAMPLE_W-1:0] w_sample;

  // A held output beat freezes every stage and the accumulator together.
  assign w_stall      = r_out_valid && !bus.out_ready;
  assign w_adv        = !w_stall;
  assign w_cfg_fire   = bus.cfg_valid && r_cfg_ready;
  assign w_issue      = (r_state == RUN) && enable && w_adv;
  assign w_pipe_empty = !r_s1_valid && !r_s2_valid && !r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cfg_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_freq      <= '0;
      r_amp       <= '0;
      r_acc       <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        IDLE: begin
          if (w_cfg_fire) begin
            r_freq <= bus.cfg_freq;
            r_amp  <= bus.cfg_amp;
            r_acc  <= bus.cfg_phase;
          end
          if (enable) begin
            r_state     <= RUN;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            r_state <= DRAIN;
          end else if (w_adv) begin
            r_acc <= r_acc + r_freq;
          end
        end
        DRAIN: begin
          // The accumulator is left alone so a later run continues phase-continuously.
          if (w_pipe_empty) begin
            r_state     <= IDLE;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cfg_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign w_quad     = quad_t'(r_s1_phase[PHASE_W-1 -: 2]);
  assign w_dec      = decode_quad(w_quad);
  assign w_raw_addr = r_s1_phase[PHASE_W-3 -: LUT_ADDR_W];
  assign w_lut_addr = w_dec.mirror ? (LUT_LEN - {1'b0, w_raw_addr}) : {1'b0, w_raw_addr};

  sine_qlut #(
    .LUT_ADDR_W (LUT_ADDR_W),
    .SAMPLE_W   (SAMPLE_W)
  ) u_qlut (
    .i_addr  (w_lut_addr),
    .o_value (w_lut)
  );

  // Amplitude is zero-extended so the signed multiply never treats it as negative.
  assign w_lut_ext = PROD_W'(r_s2_lut);
  assign w_amp_ext = PROD_W'(r_amp);
  assign w_prod    = w_lut_ext * w_amp_ext;
  assign w_sample  = SAMPLE_W'(w_prod >>> AMP_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_phase   <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_phase   <= '0;
      r_s2_lut     <= '0;
      r_out_valid  <= 1'b0;
      r_out_phase  <= '0;
      r_out_sample <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_issue;
      if (w_issue) r_s1_phase <= r_acc;

      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_phase <= r_s1_phase;
        r_s2_lut   <= w_dec.negate ? -w_lut : w_lut;
      end

      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_phase  <= r_s2_phase;
        r_out_sample <= w_sample;
      end
    end
  end

  assign bus.cfg_ready  = r_cfg_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_sample = r_out_sample;
  assign bus.out_phase  = r_out_phase;
  assign busy           = r_busy;

endmodule

// File: tb/tb_ac_stim_nco.sv
// Self-checking bench for ac_stim_nco: directed boundary cases plus randomized runs
// scored against a real-arithmetic sine model and an expected-phase sequence.
module tb_ac_stim_nco;
  import ac_stim_pkg::*;

  localparam int PW = 24;
  localparam int LW = 8;
  localparam int SW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic busy;

  ac_stim_nco_if #(.PHASE_W(PW), .SAMPLE_W(SW), .AMP_W(AW)) bus ();

  ac_stim_nco #(
    .PHASE_W    (PW),
    .LUT_ADDR_W (LW),
    .SAMPLE_W   (SW),
    .AMP_W      (AW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .busy   (busy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample for a phase straight from the sine/quadrant/floor rules, in real arithmetic.
  function automatic longint model_sample(input logic [23:0] phase, input int amp);
    int     quad;
    int     addr;
    int     idx;
    real    mag;
    longint lut;
    quad = int'(phase[23:22]);
    addr = int'(phase[21:14]);
    idx  = (quad % 2 == 1) ? 256 - addr : addr;
    mag  = real'(FULL_SCALE) * $sin(real'(idx) * 3.14159265358979323846 / 512.0);
    lut  = longint'($rtoi(mag + 0.5));
    if (quad >= 2) lut = -lut;
    return longint'($floor(real'(lut) * real'(amp) / 65536.0));
  endfunction

  // Scoreboard: the head of the expected phase stream must be on the bus whenever out_valid is high.
  bit          mon_en = 1'b0;
  logic [23:0] m_phase = '0;
  logic [23:0] m_freq = '0;
  int          m_amp = 0;
  int          beat_cnt = 0;

  always @(negedge clk) begin
    if (mon_en && rst_n && bus.out_valid) begin
      check("mon_phase", bus.out_phase, m_phase);
      check("mon_sample", bus.out_sample, model_sample(m_phase, m_amp));
      if (bus.out_ready) begin
        beat_cnt++;
        m_phase = m_phase + m_freq;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic do_cfg(input logic [23:0] f, input logic [23:0] p, input int a, input bit en);
    bus.cfg_valid = 1'b1;
    bus.cfg_freq  = f;
    bus.cfg_phase = p;
    bus.cfg_amp   = 16'(a);
    if (en) enable = 1'b1;
    @(negedge clk);
    check("cfg_ready_idle", bus.cfg_ready, 1);
    @(posedge clk);
    m_freq  = f;
    m_phase = p;
    m_amp   = a;
    #1;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready);
    int n;
    n = 0;
    while (busy && n < budget) begin
      bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    check("idle_reached", busy, 0);
    check("idle_cfg_ready", bus.cfg_ready, 1);
    bus.out_ready = 1'b1;
  endtask

  task automatic wait_out_phase(input logic [23:0] ph, input int budget);
    int n;
    n = 0;
    while (!(bus.out_valid && bus.out_phase == ph) && n < budget) begin
      tick();
      n++;
    end
    check("wait_phase_found", (bus.out_valid && bus.out_phase == ph), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0]     seq_phase [4];
    longint          seq_sample [4];
    int              start;
    logic [23:0]     f;
    logic [23:0]     p;
    int              a;

    seq_phase[0] = 24'h000000; seq_sample[0] = 0;
    seq_phase[1] = 24'h400000; seq_sample[1] = 16383;
    seq_phase[2] = 24'h800000; seq_sample[2] = 0;
    seq_phase[3] = 24'hC00000; seq_sample[3] = -16384;

    bus.cfg_valid = 1'b0;
    bus.cfg_freq  = '0;
    bus.cfg_phase = '0;
    bus.cfg_amp   = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_cfg_ready", bus.cfg_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sample", bus.out_sample, 0);
    check("rst_out_phase", bus.out_phase, 0);
    check("rst_busy", busy, 0);
    mon_en = 1'b1;

    // Quarter-cycle steps: latency and the four cardinal samples.
    do_cfg(24'h400000, 24'h000000, 32'h8000, 1'b0);
    enable = 1'b1;
    tick();
    check("t1_busy", busy, 1);
    check("t1_cfg_ready_run", bus.cfg_ready, 0);
    check("t1_lat_e0", bus.out_valid, 0);
    tick();
    check("t1_lat_e1", bus.out_valid, 0);
    tick();
    check("t1_lat_e2", bus.out_valid, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      check("t1_valid", bus.out_valid, 1);
      check("t1_phase", bus.out_phase, seq_phase[k % 4]);
      check("t1_sample", bus.out_sample, seq_sample[k % 4]);
      tick();
    end
    enable = 1'b0;
    wait_idle(50, 1'b0);

    // Hold the second sample for 5 cycles, then resume with no gap or repeat.
    do_cfg(24'h400000, 24'h000000, 32'h8000, 1'b0);
    enable = 1'b1;
    wait_out_phase(24'h400000, 20);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_hold_valid", bus.out_valid, 1);
      check("t2_hold_sample", bus.out_sample, 16383);
    end
    bus.out_ready = 1'b1;
    tick();
    check("t2_resume_phase0", bus.out_phase, 24'h800000);
    check("t2_resume_sample0", bus.out_sample, 0);
    tick();
    check("t2_resume_phase1", bus.out_phase, 24'hC00000);
    check("t2_resume_sample1", bus.out_sample, -16384);
    enable = 1'b0;
    wait_idle(50, 1'b0);

    // Accumulator wrap; config accepted on the same edge that starts the run.
    do_cfg(24'h000002, 24'hFFFFFF, 32'h8000, 1'b1);
    wait_out_phase(24'hFFFFFF, 20);
    check("t3_first_sample", bus.out_sample, -101);
    tick();
    check("t3_wrap_phase", bus.out_phase, 24'h000001);
    check("t3_wrap_sample", bus.out_sample, 0);
    enable = 1'b0;
    wait_idle(50, 1'b0);

    // Config offered in RUN is ignored; dropping enable drains exactly the 3 in-flight samples.
    do_cfg(24'h123456, 24'h040000, 32'h6000, 1'b0);
    enable = 1'b1;
    repeat (6) tick();
    bus.cfg_valid = 1'b1;
    bus.cfg_amp   = '0;
    bus.cfg_freq  = 24'h000001;
    bus.cfg_phase = 24'h777777;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_cfg_ready_run", bus.cfg_ready, 0);
      tick();
    end
    bus.cfg_valid = 1'b0;
    start  = beat_cnt;
    enable = 1'b0;
    wait_idle(50, 1'b0);
    check("t4_drain_beats", beat_cnt - start, 3);
    check("t4_out_valid_idle", bus.out_valid, 0);

    // Asynchronous reset while a beat is held.
    do_cfg(24'h111111, 24'h200000, 32'h7000, 1'b0);
    enable = 1'b1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 10 && !bus.out_valid; k++) tick();
    check("t5_pre_valid", bus.out_valid, 1);
    check("t5_pre_sample_nz", (bus.out_sample != 0), 1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", bus.out_valid, 0);
    check("t5_async_sample", bus.out_sample, 0);
    check("t5_async_busy", busy, 0);
    enable = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t5_post_cfg_ready", bus.cfg_ready, 1);
    check("t5_post_valid", bus.out_valid, 0);
    mon_en = 1'b1;

    // Peak amplitude, constant output at freq=0, and valid all-zero output at amp=0.
    do_cfg(24'h400000, 24'h000000, 32'hFFFF, 1'b1);
    wait_out_phase(24'h400000, 20);
    check("t6_peak", bus.out_sample, 32766);
    enable = 1'b0;
    wait_idle(50, 1'b0);
    do_cfg(24'h000000, 24'h400000, 32'hFFFF, 1'b1);
    wait_out_phase(24'h400000, 20);
    for (int k = 0; k < 6; k++) begin
      check("t6_const_valid", bus.out_valid, 1);
      check("t6_const_sample", bus.out_sample, 32766);
      tick();
    end
    enable = 1'b0;
    wait_idle(50, 1'b0);
    do_cfg(24'h0ABCDE, 24'h3A5A5A, 0, 1'b1);
    repeat (4) tick();
    for (int k = 0; k < 4; k++) begin
      check("t6_amp0_valid", bus.out_valid, 1);
      check("t6_amp0_sample", bus.out_sample, 0);
      tick();
    end
    enable = 1'b0;
    wait_idle(50, 1'b0);

    // Randomized runs: random config, random backpressure, reuse of held phase, re-enable in DRAIN.
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 4))
        0:       f = 24'h000000;
        1:       f = 24'h800000;
        default: f = 24'($urandom());
      endcase
      p = 24'($urandom());
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF : int'($urandom_range(0, 65535));
      if (it == 0 || $urandom_range(0, 3) != 0) do_cfg(f, p, a, 1'($urandom_range(0, 1)));
      enable = 1'b1;
      for (int k = 0; k < int'($urandom_range(10, 40)); k++) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      if ($urandom_range(0, 1) == 1) begin
        enable = 1'b0;
        tick();
        enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
      enable = 1'b0;
      wait_idle(300, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ac_stim_nco.md
Name: ac_stim_nco

Overview:
- Digital stimulus generator upstream of the AC voltage/current source models.
- Produces a phase-accurate, amplitude-scaled sine sample stream that drives the source value, one sample per accepted output beat.
- Provides the start-phase control the source models do not provide.
- Numerically controlled oscillator: phase accumulator, quarter-wave lookup, amplitude multiply, 3-stage pipeline with full backpressure.

Parameters:
- PHASE_W, 24, phase accumulator width; one full cycle = 2^PHASE_W.
- LUT_ADDR_W, 8, quarter-wave table address width; table holds 2^LUT_ADDR_W+1 entries.
- SAMPLE_W, 16, signed output sample width; table full scale = 2^(SAMPLE_W-1)-1.
- AMP_W, 16, unsigned amplitude width; gain = cfg_amp / 2^AMP_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready.
- cfg_freq  in  PHASE_W  phase increment per sample.
- cfg_phase  in  PHASE_W  start phase.
- cfg_amp  in  AMP_W  amplitude.
- enable  in  1  run request, level-sensitive.
- out_valid  out  1  sample valid.
- out_ready  in  1  consumer ready.
- out_sample  out  SAMPLE_W  signed sample.
- out_phase  out  PHASE_W  accumulator phase that produced out_sample.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, cfg_ready=1, out_valid=0, out_sample=0, out_phase=0, busy=0. All pipeline valids and config registers (freq, phase, amp) are cleared to 0.
- States: IDLE, RUN, DRAIN.
  - IDLE:
    - cfg_ready=1; an accepted config latches freq/phase/amp and loads acc=cfg_phase.
    - enable=1 -> RUN on the next edge. If cfg is accepted on that same edge, the new config is used.
  - RUN:
    - cfg_ready=0; cfg_valid is ignored.
    - Each non-stalled cycle issues one phase into stage 1 and then does acc += freq, modulo 2^PHASE_W (wrap silent).
    - enable=0 -> DRAIN; no new phase is issued from that edge.
  - DRAIN:
    - No issue. Pipeline empties under normal handshake.
    - When all stage valids = 0 and out_valid = 0 -> IDLE.
    - The accumulator is held, so a re-enable without new config continues phase-continuously.
- Pipeline:
  - S1 registers the phase.
  - S2 decodes quadrant = phase[PHASE_W-1:PHASE_W-2] and addr = next LUT_ADDR_W bits (lower bits truncated, not rounded).
    - Quadrants 0/2 use addr; quadrants 1/3 use the mirrored address 2^LUT_ADDR_W - addr.
    - Quadrants 2/3 negate the table value.
  - S3 computes (signed lut * unsigned amp) >>> AMP_W (floor) into out_sample.
  - Latency: 3 cycles from issue to out_valid with out_ready held high; throughput is 1 sample/cycle.
- Backpressure: out_valid && !out_ready stalls all stages and the accumulator. out_sample and out_phase stay stable while stalled; no sample is dropped or duplicated.
- Table: entry i = round((2^(SAMPLE_W-1)-1) * sin(i*pi/2/2^LUT_ADDR_W)). Entry 0 = 0; entry 2^LUT_ADDR_W = full scale.
- Width rule: product width is SAMPLE_W+AMP_W+1 (the amplitude is zero-extended to a signed operand). With cfg_amp < 2^AMP_W the result always fits SAMPLE_W, so no saturation is needed.
- Boundary cases:
  - freq=0 gives a constant sample at cfg_phase.
  - amp=0 gives all-zero samples that are still valid.
  - freq=2^(PHASE_W-1) alternates between phase p and p+half-cycle.
  - enable toggling 1->0->1 within DRAIN completes the drain first, then re-enters RUN from IDLE.
  - Reset mid-stream clears immediately: no partial beat is emitted and out_valid drops asynchronously.

Decomposition:
- Package ac_stim_pkg holds:
  - width defaults;
  - the state enum {IDLE, RUN, DRAIN};
  - the quadrant type and a function that decodes quadrant/mirrored address;
  - the constant FULL_SCALE.
- Sub-module sine_qlut: a combinational or registered quarter-wave ROM, generated from LUT_ADDR_W/SAMPLE_W, instantiated in S2.

Test Plan (defaults):
1. cfg freq=0x400000, phase=0, amp=0x8000, enable=1, out_ready=1 -> first out_valid 3 cycles after RUN entry. Samples repeat 0, 16383, 0, -16384; out_phase is 0x000000, 0x400000, 0x800000, 0xC00000.
2. Same config, out_ready low for 5 cycles on the 2nd sample -> out_sample is held at 16383 with out_valid=1. Resuming yields 0, -16384 with no gap or duplicate.
3. cfg phase=0xFFFFFF, freq=0x000002 -> the second out_phase is 0x000001 (wrap). Samples are table[255]-negated mirror, then 0.
4. In RUN, drive cfg_valid with amp=0 -> cfg_ready=0 and the amplitude is unchanged. Drop enable -> 3 in-flight samples are delivered, then busy=0 and state=IDLE.
5. Assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid and out_sample read 0 immediately. After release, cfg_ready=1.
6. amp=0xFFFF, freq=0x400000 -> peak sample 32766. freq=0 with phase=0x400000 -> constant 32766 every cycle.
